// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two private result FIFOs (ALU, LSB) drained one
// head per cycle by round-robin onto a registered CDB broadcast.

module cdb_fifo #(
    parameter int DEPTH  = 4,
    parameter int ROB_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              i_clear,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [ROB_W-1:0]  i_tag,
    input  logic [DATA_W-1:0] i_val,
    output logic              o_full,
    output logic              o_empty,
    output logic [ROB_W-1:0]  o_tag,
    output logic [DATA_W-1:0] o_val
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ROB_W-1:0]  r_tag [DEPTH];
    logic [DATA_W-1:0] r_val [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;

    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_tag[r_tail] <= i_tag;
                r_val[r_tail] <= i_val;
                r_tail        <= r_tail + PW'(1);
            end
            if (i_pop) begin
                r_head <= r_head + PW'(1);
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_tag   = r_tag[r_head];
    assign o_val   = r_val[r_head];
endmodule

module cdb_arbiter #(
    parameter int DEPTH  = 4,
    parameter int ROB_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clr,
    input  logic              ALU_S,
    input  logic [ROB_W-1:0]  ALU_Reorder,
    input  logic [DATA_W-1:0] ALU_Value,
    output logic              ALU_full,
    input  logic              LSB_S,
    input  logic [ROB_W-1:0]  LSB_Reorder,
    input  logic [DATA_W-1:0] LSB_Value,
    output logic              LSB_full,
    output logic              CDB_S,
    output logic [ROB_W-1:0]  CDB_Reorder,
    output logic [DATA_W-1:0] CDB_Value,
    output logic              CDB_Src,
    output logic              err_overflow
);
    typedef enum logic {SRC_ALU = 1'b0, SRC_LSB = 1'b1} src_e;

    logic              w_clear;
    logic              w_run;
    logic              w_a_push, w_l_push;
    logic              w_a_pop,  w_l_pop;
    logic              w_a_ovf,  w_l_ovf;
    logic              w_a_empty, w_l_empty;
    logic [ROB_W-1:0]  w_a_tag, w_l_tag;
    logic [DATA_W-1:0] w_a_val, w_l_val;
    logic              w_gnt;
    src_e              w_gnt_src;

    logic              r_s;
    logic [ROB_W-1:0]  r_tag;
    logic [DATA_W-1:0] r_val;
    src_e              r_src;
    src_e              r_last;
    logic              r_err;

    assign w_clear  = rst | clr;
    assign w_run    = rdy & ~w_clear;
    // Fullness is judged on the pre-edge count, so a same-cycle pop never frees room.
    assign w_a_push = w_run & ALU_S & ~ALU_full;
    assign w_l_push = w_run & LSB_S & ~LSB_full;
    assign w_a_ovf  = w_run & ALU_S & ALU_full;
    assign w_l_ovf  = w_run & LSB_S & LSB_full;

    cdb_fifo #(.DEPTH(DEPTH), .ROB_W(ROB_W), .DATA_W(DATA_W)) u_alu_fifo (
        .clk(clk), .i_clear(w_clear), .i_push(w_a_push), .i_pop(w_a_pop),
        .i_tag(ALU_Reorder), .i_val(ALU_Value),
        .o_full(ALU_full), .o_empty(w_a_empty), .o_tag(w_a_tag), .o_val(w_a_val)
    );

    cdb_fifo #(.DEPTH(DEPTH), .ROB_W(ROB_W), .DATA_W(DATA_W)) u_lsb_fifo (
        .clk(clk), .i_clear(w_clear), .i_push(w_l_push), .i_pop(w_l_pop),
        .i_tag(LSB_Reorder), .i_val(LSB_Value),
        .o_full(LSB_full), .o_empty(w_l_empty), .o_tag(w_l_tag), .o_val(w_l_val)
    );

    always_comb begin
        w_gnt     = 1'b0;
        w_gnt_src = SRC_ALU;
        if (w_run) begin
            if (!w_a_empty && !w_l_empty) begin
                w_gnt     = 1'b1;
                w_gnt_src = (r_last == SRC_LSB) ? SRC_ALU : SRC_LSB;
            end else if (!w_a_empty) begin
                w_gnt     = 1'b1;
                w_gnt_src = SRC_ALU;
            end else if (!w_l_empty) begin
                w_gnt     = 1'b1;
                w_gnt_src = SRC_LSB;
            end
        end
    end

    assign w_a_pop = w_gnt & (w_gnt_src == SRC_ALU);
    assign w_l_pop = w_gnt & (w_gnt_src == SRC_LSB);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s    <= 1'b0;
            r_tag  <= '0;
            r_val  <= '0;
            r_src  <= SRC_ALU;
            r_last <= SRC_LSB;
            r_err  <= 1'b0;
        end else if (clr) begin
            r_s    <= 1'b0;
            r_last <= SRC_LSB;
            r_err  <= 1'b0;
        end else if (rdy) begin
            r_s   <= w_gnt;
            r_err <= r_err | w_a_ovf | w_l_ovf;
            if (w_gnt) begin
                r_tag  <= (w_gnt_src == SRC_ALU) ? w_a_tag : w_l_tag;
                r_val  <= (w_gnt_src == SRC_ALU) ? w_a_val : w_l_val;
                r_src  <= w_gnt_src;
                r_last <= w_gnt_src;
            end
        end else begin
            r_s <= 1'b0;
        end
    end

    assign CDB_S        = r_s;
    assign CDB_Reorder  = r_tag;
    assign CDB_Value    = r_val;
    assign CDB_Src      = r_src;
    assign err_overflow = r_err;
endmodule
